// File: rtl/seq_multiplier_16b.sv
// Iterative shift-add unsigned multiplier, 16b x 16b -> 32b, one add/shift step per clock.
// WIDTH is tied to the 16-bit adder below; only WIDTH=16 is meaningful.

module full_adder_16b (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {16'd0, i_cin};
endmodule

module seq_multiplier_16b #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_load;
  logic                w_last;

  logic [WIDTH-1:0]    r_mc;
  logic [WIDTH:0]      r_acc;
  logic [WIDTH-1:0]    r_lo;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*WIDTH-1:0]  r_product;
  logic                r_ovf;

  logic [WIDTH-1:0]    w_add;
  logic                w_cout;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH:0]      w_acc_shift;
  logic [WIDTH-1:0]    w_lo_shift;

  full_adder_16b u_adder (
    .i_a    (r_acc[WIDTH-1:0]),
    .i_b    (r_mc),
    .i_cin  (1'b0),
    .o_sum  (w_add),
    .o_cout (w_cout)
  );

  // r_acc[WIDTH] is always 0 after a shift, so the pass-through path is {0, hi}.
  assign w_sum       = r_lo[0] ? {w_cout, w_add} : r_acc;
  assign w_acc_shift = {1'b0, w_sum[WIDTH:1]};
  assign w_lo_shift  = {w_sum[0], r_lo[WIDTH-1:1]};
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_load       = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_load       = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mc      <= '0;
      r_acc     <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_ovf     <= 1'b0;
    end else if (w_load) begin
      r_mc  <= mcand;
      r_acc <= '0;
      r_lo  <= mplier;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_shift;
      r_lo  <= w_lo_shift;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_product <= {w_acc_shift[WIDTH-1:0], w_lo_shift};
        r_ovf     <= |w_acc_shift[WIDTH-1:0];
      end
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign product = r_product;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_seq_multiplier_16b.sv
// Self-checking bench for seq_multiplier_16b: directed corner cases plus random operands
// compared against a plain-arithmetic product model.

module tb_seq_multiplier_16b;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] held_prod;

  always #5 clk = ~clk;

  seq_multiplier_16b dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One multiply from an idle/done state; optional extra start pulse mid-run.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int pulse_step);
    logic [31:0] exp_p;
    int busy_cnt;
    int hold_bad;
    int done_bad;
    exp_p    = 32'(a) * 32'(b);
    busy_cnt = 0;
    hold_bad = 0;
    done_bad = 0;
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    mcand  = 16'($urandom);
    mplier = 16'($urandom);
    for (int i = 1; i <= 15; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b0) done_bad++;
      if (product !== held_prod) hold_bad++;
      if (i == pulse_step) begin
        start  = 1'b1;
        mcand  = 16'd7;
        mplier = 16'd7;
      end
      tick();
      start = 1'b0;
    end
    chk("run_busy_cycles", 32'(busy_cnt), 32'd15);
    chk("run_no_early_done", 32'(done_bad), 32'd0);
    chk("run_product_held", 32'(hold_bad), 32'd0);
    chk("busy_last_step", {31'd0, busy}, 32'd1);
    tick();
    chk("done_at_17", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    chk("product", product, exp_p);
    chk("ovf", {31'd0, ovf}, {31'd0, (exp_p[31:16] != 16'd0)});
    $display("mul 0x%04h x 0x%04h -> 0x%08h ovf=%0b (model 0x%08h)", a, b, product, ovf, exp_p);
    held_prod = exp_p;
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("product_after_done", product, held_prod);
  endtask

  initial begin
    int dcount;
    int hold_bad;
    rst    = 1'b1;
    start  = 1'b1;
    mcand  = 16'h1111;
    mplier = 16'h2222;
    held_prod = 32'd0;
    tick();
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", product, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    tick();
    chk("idle_no_busy", {31'd0, busy}, 32'd0);

    run_mul(16'd3, 16'd5, -1);
    run_mul(16'hFFFF, 16'hFFFF, -1);
    run_mul(16'h8000, 16'h0002, -1);

    // Second start during RUN must be ignored.
    run_mul(16'h1234, 16'h0000, 5);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) dcount++;
      tick();
    end
    chk("no_spurious_done", 32'(dcount), 32'd0);

    // Reset mid-run aborts and clears the product.
    mcand  = 16'h00FF;
    mplier = 16'h0101;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", product, 32'd0);
    rst = 1'b0;
    held_prod = 32'd0;
    run_mul(16'h00FF, 16'h0101, -1);

    // Start held across DONE: back-to-back multiplies.
    mcand  = 16'd2;
    mplier = 16'd3;
    start  = 1'b1;
    tick();
    mcand  = 16'd4;
    mplier = 16'd5;
    for (int i = 0; i < 15; i++) tick();
    tick();
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk("b2b_product1", product, 32'h6);
    tick();
    chk("b2b_reload_busy", {31'd0, busy}, 32'd1);
    hold_bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (product !== 32'h6) hold_bad++;
      tick();
    end
    chk("b2b_product1_held", 32'(hold_bad), 32'd0);
    tick();
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk("b2b_product2", product, 32'h14);
    start = 1'b0;
    tick();
    chk("b2b_idle_done", {31'd0, done}, 32'd0);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    held_prod = 32'h14;

    for (int n = 0; n < 20; n++) begin
      run_mul(16'($urandom), 16'($urandom), -1);
    end
    run_mul(16'd1, 16'hFFFF, -1);
    run_mul(16'hFFFF, 16'd0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
